// File: rtl/fifo_arb_pkg.sv
// Shared constants for the two-producer FIFO write arbiter.
package fifo_arb_pkg;

   localparam int BURST_MAX_DEFAULT = 4;
   localparam int BURST_CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic any,
   output logic pick
);

   assign any  = req0 | req1;
   assign pick = (req0 & req1) ? ~last_owner : req1;

endmodule

// File: rtl/fifo_arbiter.sv
// Burst-limited round-robin arbiter for two producers sharing one FIFO write port,
// plus a pass-through read strobe with a one-cycle valid.
//
// state   | meaning
// IDLE    | no producer owns the write port
// OWN0    | producer 0 owns the write port (gnt0)
// OWN1    | producer 1 owns the write port (gnt1)
module fifo_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DATA_W-1:0] din0,
   output logic              ack0,
   input  logic              req1,
   input  logic [DATA_W-1:0] din1,
   output logic              ack1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [DATA_W-1:0] fifo_din,
   output logic              fifo_wr_en,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [15:0]       wr_total
);

   localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(BURST_MAX - 1);

   arb_state_t             state, state_nxt;
   logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;
   logic                   last_owner, last_nxt;
   logic                   own_req, release_own, decide;
   logic                   pick_any, pick_id;

   assign gnt0       = (state == ST_OWN0);
   assign gnt1       = (state == ST_OWN1);
   assign ack0       = gnt0 & req0 & ~fifo_full;
   assign ack1       = gnt1 & req1 & ~fifo_full;
   assign fifo_wr_en = ack0 | ack1;
   assign fifo_din   = gnt0 ? din0 : (gnt1 ? din1 : '0);
   assign fifo_rd_en = rd_req & ~fifo_empty & ~rst;

   assign own_req     = gnt0 ? req0 : req1;
   assign release_own = (gnt0 | gnt1) &
                        (~own_req | (fifo_wr_en & (burst_cnt == LAST_BEAT)));

   // While owning, last_owner equals the owner, so the same pick rule gives
   // "other first, else same again" on release.
   rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_owner),
      .any        (pick_any),
      .pick       (pick_id)
   );

   always_comb begin
      state_nxt = state;
      burst_nxt = burst_cnt;
      last_nxt  = last_owner;
      decide    = 1'b0;
      case (state)
         ST_OWN0, ST_OWN1: begin
            if (release_own) decide = 1'b1;
            else             burst_nxt = burst_cnt + BURST_CNT_W'(fifo_wr_en);
         end
         default: decide = 1'b1;
      endcase
      if (decide) begin
         burst_nxt = '0;
         if (pick_any) begin
            state_nxt = pick_id ? ST_OWN1 : ST_OWN0;
            last_nxt  = pick_id;
         end else begin
            state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
         rd_valid   <= 1'b0;
         wr_total   <= '0;
      end else begin
         state      <= state_nxt;
         burst_cnt  <= burst_nxt;
         last_owner <= last_nxt;
         rd_valid   <= fifo_rd_en;
         wr_total   <= wr_total + 16'(fifo_wr_en);
      end
   end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: vector table, directed corner sequences and a random run,
// all shadowed by a cycle-level reference model of the arbitration rules.
module tb_fifo_arbiter;

   localparam int DW = 16;
   localparam int BM = 4;

   logic          clk, rst;
   logic          req0, req1, ack0, ack1, gnt0, gnt1;
   logic [DW-1:0] din0, din1, fifo_din;
   logic          fifo_wr_en, fifo_full, fifo_empty, fifo_rd_en, rd_req, rd_valid;
   logic [15:0]   wr_total;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   fifo_arbiter #(.DATA_W(DW), .BURST_MAX(BM)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .din0       (din0),
      .ack0       (ack0),
      .req1       (req1),
      .din1       (din1),
      .ack1       (ack1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .rd_req     (rd_req),
      .rd_valid   (rd_valid),
      .wr_total   (wr_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner -1 means nobody holds the write port.
   int          m_owner = -1;
   int          m_burst = 0;
   int          m_last  = 1;
   logic        m_rdv   = 1'b0;
   logic [15:0] m_total = 16'd0;

   always @(posedge clk or posedge rst) begin
      bit a0, a1, acc, own_rq, oth_rq, decide;
      if (rst) begin
         m_owner = -1;
         m_burst = 0;
         m_last  = 1;
         m_rdv   = 1'b0;
         m_total = 16'd0;
      end else begin
         a0      = (m_owner == 0) && req0 && !fifo_full;
         a1      = (m_owner == 1) && req1 && !fifo_full;
         acc     = a0 || a1;
         m_total = m_total + 16'(acc);
         m_rdv   = rd_req && !fifo_empty;
         decide  = 0;
         own_rq  = (m_owner == 0) ? req0 : req1;
         oth_rq  = (m_owner == 0) ? req1 : req0;
         if (m_owner < 0)                      decide = 1;
         else if (!own_rq)                     decide = 1;
         else if (acc && m_burst == BM - 1)    decide = 1;
         else                                  m_burst = m_burst + int'(acc);
         if (decide) begin
            m_burst = 0;
            if (m_owner < 0) begin
               if (req0 && req1) m_owner = 1 - m_last;
               else if (req0)    m_owner = 0;
               else if (req1)    m_owner = 1;
            end else if (oth_rq) begin
               m_owner = 1 - m_owner;
            end else if (!own_rq) begin
               m_owner = -1;
            end
            if (m_owner >= 0) m_last = m_owner;
         end
      end
   end

   always @(negedge clk) begin
      logic e_g0, e_g1, e_a0, e_a1;
      logic [DW-1:0] e_din;
      if (chk_en) begin
         e_g0  = (m_owner == 0);
         e_g1  = (m_owner == 1);
         e_a0  = e_g0 && req0 && !fifo_full;
         e_a1  = e_g1 && req1 && !fifo_full;
         e_din = e_g0 ? din0 : (e_g1 ? din1 : '0);
         check("model_ctl",
               {25'd0, gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_rd_en, rd_valid},
               {25'd0, e_g0, e_g1, e_a0, e_a1, e_a0 | e_a1,
                rd_req & ~fifo_empty & ~rst, m_rdv});
         check("model_din", 32'(fifo_din), 32'(e_din));
         check("model_total", 32'(wr_total), 32'(m_total));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic       r0, r1, full, empty, rdq;
      logic [6:0] exp;   // {gnt0, gnt1, ack0, ack1, wr_en, rd_en, rd_valid}
   } vec_t;

   vec_t vecs[15];

   initial begin
      int n, gaps, c;
      bit granted, took;
      logic [DW-1:0] got[6];
      logic [15:0] owners;
      logic [5:0] rd_pat, rv_pat;

      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1010100};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1010100};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1000000};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1010100};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1010110};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'b0101101};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0100000};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000000};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0101100};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0101100};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0101100};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0101100};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1010100};

      // Reset with every request active
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 16'h1111; din1 = 16'h2222;
      fifo_full = 1'b0; fifo_empty = 1'b0; rd_req = 1'b1;
      #1 rst = 1'b1;
      #11;
      check("reset_outputs",
            {22'd0, gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_rd_en, rd_valid, 3'd0},
            32'd0);
      check("reset_din", 32'(fifo_din), 32'd0);
      check("reset_total", 32'(wr_total), 32'd0);
      #9;
      chk_en = 1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Vector table from a fresh reset
      do_reset();
      for (int i = 0; i < 15; i++) begin
         req0 = vecs[i].r0; req1 = vecs[i].r1; fifo_full = vecs[i].full;
         fifo_empty = vecs[i].empty; rd_req = vecs[i].rdq;
         din0 = 16'(i + 16'h0100); din1 = 16'(i + 16'h0200);
         @(negedge clk);
         check($sformatf("vec%0d", i),
               {25'd0, gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_rd_en, rd_valid},
               {25'd0, vecs[i].exp});
         next_cycle();
      end

      // Lone producer 0: six words straight through a burst boundary
      req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
      do_reset();
      req0 = 1'b1; din0 = 16'd1; n = 0; gaps = 0; granted = 0;
      for (int i = 0; i < 6; i++) got[i] = '0;
      for (int k = 0; k < 30 && n < 6; k++) begin
         @(negedge clk);
         if (gnt0) granted = 1;
         else if (granted) gaps++;
         took = ack0;
         if (ack0) begin got[n] = fifo_din; n++; end
         next_cycle();
         if (took) din0 = din0 + 16'd1;
      end
      req0 = 1'b0;
      check("solo_count", 32'(n), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("solo_word%0d", i), 32'(got[i]), 32'(i + 1));
      check("solo_gnt_gaps", 32'(gaps), 32'd0);
      @(negedge clk);
      check("solo_total", 32'(wr_total), 32'd6);
      next_cycle();

      // Both producers held: bursts of four alternate, producer 0 first
      do_reset();
      req0 = 1'b1; req1 = 1'b1; din0 = 16'hA000; din1 = 16'hB000;
      n = 0; owners = '0;
      for (int k = 0; k < 40 && n < 16; k++) begin
         @(negedge clk);
         took = ack0 | ack1;
         if (took) begin owners[n] = ack1; n++; end
         next_cycle();
         if (took && !owners[n-1]) din0 = din0 + 16'd1;
         if (took && owners[n-1])  din1 = din1 + 16'd1;
      end
      check("alt_count", 32'(n), 32'd16);
      check("alt_owners", 32'(owners), 32'h0000F0F0);

      // Full during producer 1's burst holds the count
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      c = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (gnt1) break;
         next_cycle();
         c++;
      end
      check("full_own1_reached", 32'(gnt1 & ack1), 32'd1);
      next_cycle();
      @(negedge clk);
      check("full_word2", 32'(ack1), 32'd1);
      next_cycle();
      fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("full_hold%0d", k), {30'd0, gnt1, ack1}, 32'b10);
         next_cycle();
      end
      fifo_full = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!gnt1) break;
         if (ack1) n++;
         next_cycle();
      end
      check("full_remaining", 32'(n), 32'd2);
      check("full_release_to0", {30'd0, gnt0, gnt1}, 32'b10);
      next_cycle();

      // Read strobe and its delayed valid
      req0 = 1'b0; req1 = 1'b0;
      do_reset();
      fifo_empty = 1'b0; rd_req = 1'b1; rd_pat = '0; rv_pat = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rd_pat[k] = fifo_rd_en;
         rv_pat[k] = rd_valid;
         next_cycle();
         if (k == 2) fifo_empty = 1'b1;
      end
      rd_req = 1'b0;
      check("rd_en_pattern", 32'(rd_pat), 32'b000111);
      check("rd_valid_pattern", 32'(rv_pat), 32'b001110);

      // Reset in the middle of producer 1's burst
      do_reset();
      req1 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (gnt1) break;
         next_cycle();
      end
      next_cycle();
      req0 = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("midrst_outputs", {28'd0, gnt0, gnt1, ack1, fifo_wr_en}, 32'd0);
      check("midrst_total", 32'(wr_total), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_idle", {30'd0, gnt0, gnt1}, 32'b00);
      next_cycle();
      @(negedge clk);
      check("midrst_first_gnt", {30'd0, gnt0, gnt1}, 32'b10);
      next_cycle();

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         req0       = ($urandom_range(0, 3) != 0);
         req1       = ($urandom_range(0, 3) != 0);
         fifo_full  = ($urandom_range(0, 4) == 0);
         fifo_empty = ($urandom_range(0, 3) == 0);
         rd_req     = 1'($urandom_range(0, 1));
         din0       = 16'($urandom);
         din1       = 16'($urandom);
         rst        = ($urandom_range(0, 199) == 0);
         next_cycle();
      end
      rst = 1'b0;
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
